// File: rtl/ethernec_pkg.sv
// Shared NE2000 receive-path types and constants, also imported by the register block.
package ethernec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DATA = 2'd2,
    HDR  = 2'd3
  } rx_state_e;

  localparam logic [7:0] HDR_STATUS_OK = 8'h01;
  localparam int         MAC_BYTES     = 6;
  localparam int         HDR_BYTES     = 4;
  localparam int         FRAMESIZE_DEF = 1536;
  localparam int         MINFRAME_DEF  = 60;

endpackage

// File: rtl/ethernec_rx_ctrl_if.sv
// Receive-controller port bundle: io byte stream, ring config, rx-buffer write port and status.
interface ethernec_rx_ctrl_if #(
  parameter int ABITS = 11
);
  logic             clk_en;
  logic             frame_start;
  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic             frame_end;
  logic             mac_load;
  logic [47:0]      mac;
  logic [7:0]       pstart;
  logic [7:0]       pstop;
  logic [7:0]       bnry;
  logic             curr_wr;
  logic [7:0]       curr_wdata;
  logic             buf_we;
  logic [ABITS-1:0] buf_addr;
  logic [7:0]       buf_wdata;
  logic [7:0]       curr;
  logic             prx;
  logic             ovw;
  logic             busy;
  logic [15:0]      rx_len;

  modport master (
    output clk_en, frame_start, byte_valid, rx_byte, frame_end, mac_load, mac,
           pstart, pstop, bnry, curr_wr, curr_wdata,
    input  buf_we, buf_addr, buf_wdata, curr, prx, ovw, busy, rx_len
  );

  modport slave (
    input  clk_en, frame_start, byte_valid, rx_byte, frame_end, mac_load, mac,
           pstart, pstop, bnry, curr_wr, curr_wdata,
    output buf_we, buf_addr, buf_wdata, curr, prx, ovw, busy, rx_len
  );
endinterface

// File: rtl/ethernec_ring_calc.sv
// Ring page accounting for one frame: pages needed, pages free, wrapped next curr, overflow.
// Purely combinational; 10-bit intermediates catch wrap and misconfiguration.
module ethernec_ring_calc (
  input  logic [7:0]  curr_i,
  input  logic [7:0]  bnry_i,
  input  logic [7:0]  pstart_i,
  input  logic [7:0]  pstop_i,
  input  logic [15:0] count_i,
  output logic [7:0]  need_o,
  output logic [7:0]  free_o,
  output logic [7:0]  next_o,
  output logic        overflow_o
);
  logic [16:0] need_w;
  logic [8:0]  ring_w;
  logic [9:0]  free_w;
  logic [9:0]  next_w;
  logic        cfg_err;

  always_comb begin
    need_w  = ({1'b0, count_i} + 17'd259) >> 8;
    cfg_err = (pstop_i <= pstart_i);
    ring_w  = {1'b0, pstop_i} - {1'b0, pstart_i};
    if (bnry_i > curr_i) begin
      free_w = {2'b00, bnry_i} - {2'b00, curr_i};
    end else begin
      free_w = {1'b0, ring_w} - ({2'b00, curr_i} - {2'b00, bnry_i});
    end
    next_w = {2'b00, curr_i} + need_w[9:0];
    if (next_w >= {2'b00, pstop_i}) begin
      next_w = next_w - {1'b0, ring_w};
    end
    need_o = need_w[7:0];
    // A negative free count only arises from pointers outside the ring; treat as full.
    free_o = (free_w[9:8] != 2'b00) ? 8'd0 : free_w[7:0];
    next_o = next_w[7:0];
    overflow_o = cfg_err || (need_w[16:8] != 9'd0) || (need_w[7:0] >= free_o)
                 || (next_w[9:8] != 2'b00);
  end
endmodule

// File: rtl/ethernec_rx_ctrl.sv
// NE2000 receive sequencer: owns the rx-buffer write port (MAC copy, payload, header) and curr.
// All outputs registered (one cycle after cause); no backpressure, clk_en paces MAC/header writes.
module ethernec_rx_ctrl
  import ethernec_pkg::*;
#(
  parameter int FRAMESIZE = FRAMESIZE_DEF,
  parameter int MINFRAME  = MINFRAME_DEF,
  parameter int ABITS     = 11
) (
  input logic               clk,
  input logic               reset,
  ethernec_rx_ctrl_if.slave rx
);
  localparam logic [15:0] FS_L     = 16'(FRAMESIZE);
  localparam logic [15:0] MF_L     = 16'(MINFRAME);
  localparam logic [2:0]  MAC_LAST = 3'(MAC_BYTES - 1);
  localparam logic [2:0]  HDR_LAST = 3'(HDR_BYTES - 1);

  rx_state_e        state_q, state_d;
  logic [15:0]      n_q, n_d, rx_len_q, rx_len_d, n_upd;
  logic [2:0]       k_q, k_d;
  logic [7:0]       curr_q, curr_d, next_q, next_d, buf_wdata_q, buf_wdata_d, hdr_byte;
  logic [ABITS-1:0] buf_addr_q, buf_addr_d;
  logic             buf_we_q, buf_we_d, prx_q, prx_d, ovw_q, ovw_d;
  logic             byte_take, runt, ovf;
  logic [7:0]       calc_need, calc_free, calc_next;
  logic             calc_ovf;

  // A byte arriving with frame_end is counted before the frame is judged.
  assign byte_take = rx.byte_valid && (n_q < FS_L);
  assign n_upd     = n_q + {15'd0, byte_take};
  assign runt      = (n_upd < MF_L);
  assign ovf       = calc_ovf || (calc_need >= calc_free);

  ethernec_ring_calc u_ring (
    .curr_i     (curr_q),
    .bnry_i     (rx.bnry),
    .pstart_i   (rx.pstart),
    .pstop_i    (rx.pstop),
    .count_i    (n_upd),
    .need_o     (calc_need),
    .free_o     (calc_free),
    .next_o     (calc_next),
    .overflow_o (calc_ovf)
  );

  always_comb begin
    case (k_q[1:0])
      2'd0:    hdr_byte = HDR_STATUS_OK;
      2'd1:    hdr_byte = next_q;
      2'd2:    hdr_byte = rx_len_q[7:0];
      default: hdr_byte = rx_len_q[15:8];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rx.mac_load) begin
      state_d = MAC;
    end else begin
      case (state_q)
        IDLE: if (rx.frame_start) state_d = DATA;
        MAC:  if (rx.clk_en && (k_q == MAC_LAST)) state_d = IDLE;
        DATA: if (!rx.frame_start && rx.frame_end) state_d = (runt || ovf) ? IDLE : HDR;
        HDR:  if (rx.clk_en && (k_q == HDR_LAST)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    n_d         = n_q;
    k_d         = k_q;
    next_d      = next_q;
    rx_len_d    = rx_len_q;
    curr_d      = curr_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    prx_d       = 1'b0;
    ovw_d       = 1'b0;
    if (rx.mac_load) begin
      k_d = 3'd0;
    end else begin
      case (state_q)
        IDLE: if (rx.frame_start) n_d = 16'd0;
        MAC: if (rx.clk_en) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = ABITS'(k_q);
          buf_wdata_d = 8'(rx.mac >> {k_q, 3'b000});
          k_d         = k_q + 3'd1;
        end
        DATA: if (rx.frame_start) begin
          n_d = 16'd0;
        end else begin
          if (byte_take) begin
            buf_we_d    = 1'b1;
            buf_addr_d  = ABITS'(n_q + 16'd4);
            buf_wdata_d = rx.rx_byte;
            n_d         = n_upd;
          end
          if (rx.frame_end && !runt) begin
            if (ovf) begin
              ovw_d = 1'b1;
            end else begin
              next_d   = calc_next;
              rx_len_d = n_upd + 16'd4;
              k_d      = 3'd0;
            end
          end
        end
        HDR: if (rx.clk_en) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = ABITS'(k_q);
          buf_wdata_d = hdr_byte;
          k_d         = k_q + 3'd1;
          if (k_q == HDR_LAST) begin
            curr_d = next_q;
            prx_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // CPU writes to CURR override a commit landing in the same cycle.
    if (rx.curr_wr) curr_d = rx.curr_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q         <= 16'd0;
      k_q         <= 3'd0;
      next_q      <= 8'd0;
      rx_len_q    <= 16'd0;
      curr_q      <= 8'd0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= 8'd0;
      prx_q       <= 1'b0;
      ovw_q       <= 1'b0;
    end else begin
      n_q         <= n_d;
      k_q         <= k_d;
      next_q      <= next_d;
      rx_len_q    <= rx_len_d;
      curr_q      <= curr_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      prx_q       <= prx_d;
      ovw_q       <= ovw_d;
    end
  end

  assign rx.buf_we    = buf_we_q;
  assign rx.buf_addr  = buf_addr_q;
  assign rx.buf_wdata = buf_wdata_q;
  assign rx.curr      = curr_q;
  assign rx.prx       = prx_q;
  assign rx.ovw       = ovw_q;
  assign rx.busy      = (state_q != IDLE);
  assign rx.rx_len    = rx_len_q;
endmodule

// File: tb/tb_ethernec_rx_ctrl.sv
// Bench for ethernec_rx_ctrl: random payloads and ring setups against a page-arithmetic model.
module tb_ethernec_rx_ctrl;
  localparam int FS = 1536;
  localparam int MF = 60;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ethernec_rx_ctrl_if #(.ABITS(11)) rxif ();

  ethernec_rx_ctrl #(.FRAMESIZE(FS), .MINFRAME(MF), .ABITS(11)) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rxif)
  );

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  exp_pl[$];
  int  cyc_cnt = 0;
  int  prx_cnt = 0;
  int  ovw_cnt = 0;
  int  checks = 0;
  int  errors = 0;
  int  m_curr = 0;
  int  m_rxlen = 0;
  int  exp_kind, exp_next, exp_n;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (rxif.buf_we === 1'b1) wq.push_back('{int'(rxif.buf_addr), int'(rxif.buf_wdata), cyc_cnt});
    if (rxif.prx === 1'b1) prx_cnt++;
    if (rxif.ovw === 1'b1) ovw_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
    $fatal(1, "watchdog");
  end

  task automatic set_ring(input int ps, input int pe, input int bn);
    rxif.pstart = 8'(ps);
    rxif.pstop  = 8'(pe);
    rxif.bnry   = 8'(bn);
    @(negedge clk);
  endtask

  task automatic set_curr(input int v);
    rxif.curr_wr    = 1'b1;
    rxif.curr_wdata = 8'(v);
    @(negedge clk);
    rxif.curr_wr = 1'b0;
    m_curr = v;
  endtask

  // Ring viewed as pages in [pstart,pstop): free space is the circular distance curr -> bnry.
  task automatic model(input int len);
    int need, ring, free;
    exp_n    = (len > FS) ? FS : len;
    exp_kind = 0;
    exp_next = m_curr;
    if (exp_n >= MF) begin
      need = (exp_n + 4 + 255) / 256;
      ring = int'(rxif.pstop) - int'(rxif.pstart);
      if (ring <= 0) begin
        exp_kind = 1;
      end else begin
        if (int'(rxif.bnry) == m_curr) free = ring;
        else free = (((int'(rxif.bnry) - m_curr) % ring) + ring) % ring;
        if (need >= free) begin
          exp_kind = 1;
        end else begin
          exp_kind = 2;
          exp_next = int'(rxif.pstart) + ((m_curr - int'(rxif.pstart) + need) % ring);
        end
      end
    end
  endtask

  task automatic send_frame(input int len, input bit end_last, input bit gaps);
    logic [7:0] b;
    rxif.frame_start = 1'b1;
    @(negedge clk);
    rxif.frame_start = 1'b0;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      rxif.byte_valid = 1'b1;
      rxif.rx_byte    = b;
      if (i < FS) exp_pl.push_back(int'(b));
      if (end_last && i == len - 1) rxif.frame_end = 1'b1;
      @(negedge clk);
      rxif.byte_valid = 1'b0;
      rxif.frame_end  = 1'b0;
      if (gaps) repeat ($urandom_range(0, 1)) @(negedge clk);
    end
    if (!end_last) begin
      rxif.frame_end = 1'b1;
      @(negedge clk);
      rxif.frame_end = 1'b0;
    end
  endtask

  task automatic finish_check(input string name, input bit pace, input int w0, input int p0,
                              input int o0, input int curr_ovr);
    int t, bad, nw;
    int hb[4];
    t = 0;
    bad = 0;
    while (rxif.busy === 1'b1 && t < 300) begin
      rxif.clk_en = pace ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      t++;
    end
    rxif.clk_en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (t >= 300) begin errors++; $display("FAIL %s_timeout busy=%b after %0d cycles", name, rxif.busy, t); end
    nw = exp_n + ((exp_kind == 2) ? 4 : 0);
    checks++;
    if (wq.size() - w0 != nw) begin
      errors++;
      $display("FAIL %s_wrcount got %0d exp %0d", name, wq.size() - w0, nw);
    end else begin
      for (int i = 0; i < exp_n; i++)
        if (wq[w0+i].addr != 4 + i || wq[w0+i].data != exp_pl[i]) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL %s_payload %0d bad writes exp 0", name, bad); end
      if (exp_kind == 2) begin
        hb = '{1, exp_next, (exp_n + 4) % 256, (exp_n + 4) / 256};
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (wq[w0+exp_n+j].addr != j || wq[w0+exp_n+j].data != hb[j]) begin
            errors++;
            $display("FAIL %s_hdr%0d got addr %0d data %h exp addr %0d data %h", name, j,
                     wq[w0+exp_n+j].addr, wq[w0+exp_n+j].data, j, hb[j]);
          end
        end
      end
    end
    if (exp_kind == 2) begin
      m_curr  = (curr_ovr >= 0) ? curr_ovr : exp_next;
      m_rxlen = exp_n + 4;
    end else if (curr_ovr >= 0) begin
      m_curr = curr_ovr;
    end
    checks++;
    if (prx_cnt - p0 != ((exp_kind == 2) ? 1 : 0)) begin
      errors++; $display("FAIL %s_prx got %0d pulses exp %0d", name, prx_cnt - p0, (exp_kind == 2) ? 1 : 0);
    end
    checks++;
    if (ovw_cnt - o0 != ((exp_kind == 1) ? 1 : 0)) begin
      errors++; $display("FAIL %s_ovw got %0d pulses exp %0d", name, ovw_cnt - o0, (exp_kind == 1) ? 1 : 0);
    end
    checks++;
    if (int'(rxif.curr) != m_curr) begin errors++; $display("FAIL %s_curr got %0d exp %0d", name, rxif.curr, m_curr); end
    checks++;
    if (int'(rxif.rx_len) != m_rxlen) begin errors++; $display("FAIL %s_rxlen got %0d exp %0d", name, rxif.rx_len, m_rxlen); end
    exp_pl.delete();
  endtask

  task automatic run_case(input string name, input int len, input bit end_last, input bit gaps,
                          input bit pace);
    int w0, p0, o0;
    w0 = wq.size();
    p0 = prx_cnt;
    o0 = ovw_cnt;
    model(len);
    send_frame(len, end_last, gaps);
    finish_check(name, pace, w0, p0, o0, -1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (rxif.buf_we !== 1'b0) begin errors++; $display("FAIL reset_buf_we got %b exp 0", rxif.buf_we); end
    checks++; if (rxif.buf_addr !== 11'd0) begin errors++; $display("FAIL reset_buf_addr got %h exp 0", rxif.buf_addr); end
    checks++; if (rxif.buf_wdata !== 8'd0) begin errors++; $display("FAIL reset_buf_wdata got %h exp 0", rxif.buf_wdata); end
    checks++; if (rxif.curr !== 8'd0) begin errors++; $display("FAIL reset_curr got %h exp 0", rxif.curr); end
    checks++; if (rxif.prx !== 1'b0) begin errors++; $display("FAIL reset_prx got %b exp 0", rxif.prx); end
    checks++; if (rxif.ovw !== 1'b0) begin errors++; $display("FAIL reset_ovw got %b exp 0", rxif.ovw); end
    checks++; if (rxif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rxif.busy); end
    checks++; if (rxif.rx_len !== 16'd0) begin errors++; $display("FAIL reset_rx_len got %h exp 0", rxif.rx_len); end
    m_curr  = 0;
    m_rxlen = 0;
  endtask

  task automatic test_mac();
    int w0, t, bad;
    w0 = wq.size();
    t = 0;
    bad = 0;
    rxif.mac      = 48'h665544332211;
    rxif.clk_en   = 1'b1;
    rxif.mac_load = 1'b1;
    @(negedge clk);
    rxif.mac_load = 1'b0;
    while (rxif.busy === 1'b1 && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    checks++;
    if (wq.size() - w0 != 6) begin
      errors++; $display("FAIL mac_wrcount got %0d exp 6", wq.size() - w0);
    end else begin
      for (int k = 0; k < 6; k++) begin
        if (wq[w0+k].addr != k || wq[w0+k].data != 17 * (k + 1)) bad++;
        if (k > 0 && wq[w0+k].cyc != wq[w0+k-1].cyc + 1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL mac_bytes %0d bad writes exp 0", bad); end
    end
    checks++; if (rxif.busy !== 1'b0) begin errors++; $display("FAIL mac_busy got %b exp 0", rxif.busy); end
    checks++; if (int'(rxif.curr) != m_curr) begin errors++; $display("FAIL mac_curr got %0d exp %0d", rxif.curr, m_curr); end
  endtask

  task automatic test_commit();
    set_ring(46, 80, 46);
    set_curr(47);
    run_case("commit", 100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    set_ring(46, 80, 60);
    set_curr(79);
    run_case("wrap", 300, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    set_ring(46, 80, 48);
    set_curr(47);
    run_case("ovf", 600, 1'b0, 1'b0, 1'b0);
    set_ring(46, 80, 49);
    run_case("ovf_eq", 300, 1'b1, 1'b0, 1'b0);
    run_case("fit_lt", 200, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_runt();
    set_ring(46, 80, 46);
    set_curr(50);
    run_case("runt40", 40, 1'b0, 1'b0, 1'b0);
    run_case("runt59", 59, 1'b1, 1'b0, 1'b0);
    run_case("min60", 60, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_oversize();
    int w0, maxa;
    w0 = wq.size();
    maxa = -1;
    set_ring(46, 80, 46);
    set_curr(47);
    w0 = wq.size();
    run_case("big", 1600, 1'b0, 1'b0, 1'b0);
    for (int i = w0; i < wq.size(); i++) if (wq[i].addr > maxa) maxa = wq[i].addr;
    checks++; if (maxa != 1539) begin errors++; $display("FAIL big_lastaddr got %0d exp 1539", maxa); end
  endtask

  task automatic test_mac_abort();
    int w0, p0, o0, t, bad;
    set_ring(46, 80, 46);
    set_curr(47);
    w0 = wq.size(); p0 = prx_cnt; o0 = ovw_cnt; t = 0; bad = 0;
    rxif.clk_en = 1'b1;
    send_frame(100, 1'b0, 1'b0);
    exp_pl.delete();
    repeat (2) @(negedge clk);
    rxif.mac_load = 1'b1;
    @(negedge clk);
    rxif.mac_load = 1'b0;
    while (rxif.busy === 1'b1 && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    checks++; if (prx_cnt - p0 != 0) begin errors++; $display("FAIL abort_prx got %0d exp 0", prx_cnt - p0); end
    checks++; if (ovw_cnt - o0 != 0) begin errors++; $display("FAIL abort_ovw got %0d exp 0", ovw_cnt - o0); end
    checks++; if (int'(rxif.curr) != m_curr) begin errors++; $display("FAIL abort_curr got %0d exp %0d", rxif.curr, m_curr); end
    checks++;
    if (wq.size() - w0 != 108) begin
      errors++; $display("FAIL abort_wrcount got %0d exp 108", wq.size() - w0);
    end else begin
      for (int k = 0; k < 6; k++) if (wq[w0+102+k].addr != k || wq[w0+102+k].data != 17 * (k + 1)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL abort_macbytes %0d bad exp 0", bad); end
    end
  endtask

  task automatic test_curr_wr_commit();
    int w0, p0, o0;
    set_ring(46, 80, 46);
    set_curr(50);
    w0 = wq.size(); p0 = prx_cnt; o0 = ovw_cnt;
    rxif.clk_en = 1'b1;
    model(100);
    send_frame(100, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rxif.curr_wr    = 1'b1;
    rxif.curr_wdata = 8'd60;
    @(negedge clk);
    rxif.curr_wr = 1'b0;
    finish_check("cwr", 1'b0, w0, p0, o0, 60);
  endtask

  task automatic test_cfg_err();
    set_ring(80, 46, 60);
    run_case("cfgerr", 100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int ps, pe, len;
      bit long_f;
      ps = $urandom_range(1, 150);
      pe = ps + $urandom_range(4, 60);
      set_ring(ps, pe, ps + $urandom_range(0, pe - ps - 1));
      set_curr(ps + $urandom_range(0, pe - ps - 1));
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(1537, 1600) : $urandom_range(40, 900);
      long_f = (len > 900);
      run_case("rand", len, 1'($urandom_range(0, 1)), !long_f && ($urandom_range(0, 1) == 1),
               1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    reset = 1'b1;
    rxif.clk_en = 1'b1; rxif.frame_start = 1'b0; rxif.byte_valid = 1'b0; rxif.rx_byte = 8'd0;
    rxif.frame_end = 1'b0; rxif.mac_load = 1'b0; rxif.mac = 48'd0; rxif.pstart = 8'd46;
    rxif.pstop = 8'd80; rxif.bnry = 8'd46; rxif.curr_wr = 1'b0; rxif.curr_wdata = 8'd0;
    test_reset();
    test_mac();
    test_commit();
    test_wrap();
    test_overflow();
    test_runt();
    test_oversize();
    test_mac_abort();
    test_curr_wr_commit();
    test_cfg_err();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
